// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : RISC-V immediate decode with a registered 2-entry output
//               buffer. Optional macro IMM_DECODE_ZICSR_UIMM_EN enables the
//               Z (CSR uimm) immediate format.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit C_IS_RV64 = (XLEN == 64);

    localparam logic [6:0] C_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] C_OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] C_OP_IMM      = 7'b0010011;
    localparam logic [6:0] C_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] C_OP_IMM32    = 7'b0011011;
    localparam logic [6:0] C_OP_STORE    = 7'b0100011;
    localparam logic [6:0] C_OP_OP       = 7'b0110011;
    localparam logic [6:0] C_OP_LUI      = 7'b0110111;
    localparam logic [6:0] C_OP_OP32     = 7'b0111011;
    localparam logic [6:0] C_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] C_OP_JALR     = 7'b1100111;
    localparam logic [6:0] C_OP_JAL      = 7'b1101111;
    localparam logic [6:0] C_OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] C_FMT_NONE = 3'd0;
    localparam logic [2:0] C_FMT_I    = 3'd1;
    localparam logic [2:0] C_FMT_S    = 3'd2;
    localparam logic [2:0] C_FMT_B    = 3'd3;
    localparam logic [2:0] C_FMT_U    = 3'd4;
    localparam logic [2:0] C_FMT_J    = 3'd5;
`ifdef IMM_DECODE_ZICSR_UIMM_EN
    localparam logic [2:0] C_FMT_Z    = 3'd6;
`endif

    localparam logic [1:0] C_CNT_EMPTY = 2'd0;
    localparam logic [1:0] C_CNT_FULL  = 2'd2;

    // ------------------------------------------------------------------
    // Immediate extraction
    // ------------------------------------------------------------------
    logic [6:0]      w_op;
    logic            w_sign;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_op    = in_instr[6:0];
    assign w_sign  = in_instr[31];
    assign w_imm_i = {{(XLEN-12){w_sign}}, in_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){w_sign}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){w_sign}}, in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){w_sign}}, in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};

    // The U immediate is exactly 32 bits wide, so RV32 needs no extension.
    generate
        if (C_IS_RV64) begin : g_u_rv64
            assign w_imm_u = {{(XLEN-32){w_sign}}, in_instr[31:12], 12'b0};
        end else begin : g_u_rv32
            assign w_imm_u = {in_instr[31:12], 12'b0};
        end
    endgenerate

`ifdef IMM_DECODE_ZICSR_UIMM_EN
    logic [XLEN-1:0] w_imm_z;
    assign w_imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};
`endif

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_dec_illegal;

    always_comb begin
        w_dec_imm     = '0;
        w_dec_fmt     = C_FMT_NONE;
        w_dec_illegal = 1'b0;
        case (w_op)
            C_OP_IMM, C_OP_LOAD, C_OP_JALR: begin
                w_dec_imm = w_imm_i;
                w_dec_fmt = C_FMT_I;
            end
            C_OP_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_UIMM_EN
                // funct3[2] set selects the immediate CSR forms
                if (in_instr[14]) begin
                    w_dec_imm = w_imm_z;
                    w_dec_fmt = C_FMT_Z;
                end else begin
                    w_dec_imm = w_imm_i;
                    w_dec_fmt = C_FMT_I;
                end
`else
                w_dec_imm = w_imm_i;
                w_dec_fmt = C_FMT_I;
`endif
            end
            C_OP_IMM32: begin
                if (C_IS_RV64) begin
                    w_dec_imm = w_imm_i;
                    w_dec_fmt = C_FMT_I;
                end else begin
                    w_dec_illegal = 1'b1;
                end
            end
            C_OP_STORE: begin
                w_dec_imm = w_imm_s;
                w_dec_fmt = C_FMT_S;
            end
            C_OP_BRANCH: begin
                w_dec_imm = w_imm_b;
                w_dec_fmt = C_FMT_B;
            end
            C_OP_LUI, C_OP_AUIPC: begin
                w_dec_imm = w_imm_u;
                w_dec_fmt = C_FMT_U;
            end
            C_OP_JAL: begin
                w_dec_imm = w_imm_j;
                w_dec_fmt = C_FMT_J;
            end
            C_OP_OP, C_OP_MISC_MEM: begin
                w_dec_illegal = 1'b0;
            end
            C_OP_OP32: begin
                w_dec_illegal = !C_IS_RV64;
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry result buffer
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic             ill_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (count_q != C_CNT_FULL);
    assign out_valid = (count_q != C_CNT_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = !wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= C_CNT_EMPTY;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= C_FMT_NONE;
                ill_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push) begin
                imm_q[wr_ptr_q] <= w_dec_imm;
                fmt_q[wr_ptr_q] <= w_dec_fmt;
                ill_q[wr_ptr_q] <= w_dec_illegal;
                tag_q[wr_ptr_q] <= in_tag;
            end
        end
    end

    // Popped slots keep stale data, so the head is masked when empty.
    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : C_FMT_NONE;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
    assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire
